// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: shares one HD44780 character-LCD bus between two byte writers and times RS/DATA/EN.
// Build option LCD_ARB_FIXED_PRIORITY_EN: writer 0 always wins a tie instead of round-robin.
`default_nettype none

module lcd_bus_arbiter #(
    parameter int SETUP_CYC     = 4,
    parameter int EN_HIGH_CYC   = 25,
    parameter int HOLD_CYC      = 4,
    parameter int CMD_WAIT_CYC  = 2500,
    parameter int LONG_WAIT_CYC = 82000
) (
    input  logic       CLK_50MHz,
    input  logic       resetn,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       LCD_ON,
    output logic       LCD_RW,
    output logic       LCD_RS,
    output logic       LCD_EN,
    output logic [7:0] LCD_DATA,
    output logic       busy,
    output logic       grant
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_PULSE = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    localparam logic [16:0] SETUP_LD = 17'(SETUP_CYC - 1);
    localparam logic [16:0] EN_LD    = 17'(EN_HIGH_CYC - 1);
    localparam logic [16:0] HOLD_LD  = 17'(HOLD_CYC - 1);
    localparam logic [16:0] CMD_LD   = 17'(CMD_WAIT_CYC - 1);
    localparam logic [16:0] LONG_LD  = 17'(LONG_WAIT_CYC - 1);

    logic [2:0]  state;
    logic [16:0] cnt;
    logic        winner;
    logic        long_cmd;

`ifdef LCD_ARB_FIXED_PRIORITY_EN
    always_comb begin
        winner = !req0_valid;
    end
`else
    logic last_grant;

    always_comb begin
        if (req0_valid && req1_valid) begin
            winner = !last_grant;
        end else begin
            winner = !req0_valid;
        end
    end
`endif

    assign LCD_ON = 1'b1;
    assign LCD_RW = 1'b0;

    // Clear display (0x01) and return home (0x02/0x03) need the long execution delay.
    assign long_cmd = !LCD_RS && (LCD_DATA[7:2] == 6'd0) && (LCD_DATA != 8'd0);

    always_ff @(posedge CLK_50MHz or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            cnt        <= '0;
            LCD_EN     <= 1'b0;
            LCD_RS     <= 1'b0;
            LCD_DATA   <= 8'h00;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            busy       <= 1'b0;
            grant      <= 1'b0;
`ifndef LCD_ARB_FIXED_PRIORITY_EN
            last_grant <= 1'b1;
`endif
        end else begin
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req0_valid || req1_valid) begin
                        req0_ready <= !winner;
                        req1_ready <= winner;
                        LCD_RS     <= winner ? req1_rs : req0_rs;
                        LCD_DATA   <= winner ? req1_data : req0_data;
                        grant      <= winner;
`ifndef LCD_ARB_FIXED_PRIORITY_EN
                        last_grant <= winner;
`endif
                        cnt        <= SETUP_LD;
                        busy       <= 1'b1;
                        state      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == 17'd0) begin
                        LCD_EN <= 1'b1;
                        cnt    <= EN_LD;
                        state  <= S_PULSE;
                    end else begin
                        cnt <= cnt - 17'd1;
                    end
                end
                S_PULSE: begin
                    if (cnt == 17'd0) begin
                        LCD_EN <= 1'b0;
                        cnt    <= HOLD_LD;
                        state  <= S_HOLD;
                    end else begin
                        cnt <= cnt - 17'd1;
                    end
                end
                S_HOLD: begin
                    if (cnt == 17'd0) begin
                        cnt   <= long_cmd ? LONG_LD : CMD_LD;
                        state <= S_WAIT;
                    end else begin
                        cnt <= cnt - 17'd1;
                    end
                end
                S_WAIT: begin
                    if (cnt == 17'd0) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 17'd1;
                    end
                end
                default: begin
                    LCD_EN <= 1'b0;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter: transaction-timeline model of the LCD bus arbiter with directed and random writers.
`default_nettype none

module tb_lcd_bus_arbiter;

    localparam int SETUP = 4;
    localparam int ENH   = 25;
    localparam int HOLD  = 4;
    localparam int CMDW  = 50;
    localparam int LONGW = 300;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       req0_valid = 1'b0, req0_rs = 1'b0, req1_valid = 1'b0, req1_rs = 1'b0;
    logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
    logic       req0_ready, req1_ready, LCD_ON, LCD_RW, LCD_RS, LCD_EN, busy, grant;
    logic [7:0] LCD_DATA;

    lcd_bus_arbiter #(
        .SETUP_CYC(SETUP), .EN_HIGH_CYC(ENH), .HOLD_CYC(HOLD),
        .CMD_WAIT_CYC(CMDW), .LONG_WAIT_CYC(LONGW)
    ) dut (
        .CLK_50MHz(clk), .resetn(resetn),
        .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data), .req1_ready(req1_ready),
        .LCD_ON(LCD_ON), .LCD_RW(LCD_RW), .LCD_RS(LCD_RS), .LCD_EN(LCD_EN),
        .LCD_DATA(LCD_DATA), .busy(busy), .grant(grant)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a transaction is a timeline of offsets t from its grant edge.
    function automatic int txn_len(input logic rs, input logic [7:0] d);
        bit lng;
        lng = (rs == 1'b0) && (d == 8'h01 || d == 8'h02 || d == 8'h03);
        return SETUP + ENH + HOLD + (lng ? LONGW : CMDW);
    endfunction

    function automatic bit pick(input logic v0, input logic v1, input bit last);
`ifdef LCD_ARB_FIXED_PRIORITY_EN
        return v0 ? 1'b0 : 1'b1;
`else
        if (v0 && v1) return !last;
        return v0 ? 1'b0 : 1'b1;
`endif
    endfunction

    bit         m_active = 1'b0;
    int         m_t = 0;
    int         m_total = 0;
    bit         m_grant = 1'b0;
    bit         m_last = 1'b1;
    logic       m_rs = 1'b0;
    logic [7:0] m_data = 8'h00;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_active <= 1'b0; m_t <= 0; m_total <= 0;
            m_grant <= 1'b0; m_last <= 1'b1; m_rs <= 1'b0; m_data <= 8'h00;
        end else if (m_active) begin
            m_t <= m_t + 1;
            if (m_t + 1 == m_total) m_active <= 1'b0;
        end else if (req0_valid || req1_valid) begin
            m_active <= 1'b1;
            m_t      <= 0;
            m_grant  <= pick(req0_valid, req1_valid, m_last);
            m_last   <= pick(req0_valid, req1_valid, m_last);
            m_rs     <= pick(req0_valid, req1_valid, m_last) ? req1_rs : req0_rs;
            m_data   <= pick(req0_valid, req1_valid, m_last) ? req1_data : req0_data;
            m_total  <= pick(req0_valid, req1_valid, m_last) ? txn_len(req1_rs, req1_data)
                                                             : txn_len(req0_rs, req0_data);
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("ctrl", {LCD_ON, LCD_RW, req0_ready, req1_ready, LCD_EN, busy, grant},
                {1'b1, 1'b0,
                 m_active && m_t == 0 && !m_grant,
                 m_active && m_t == 0 && m_grant,
                 m_active && m_t >= SETUP && m_t < SETUP + ENH,
                 m_active, m_grant});
            chk("bus", {LCD_RS, LCD_DATA}, {m_rs, m_data});
        end
    end

    // Observations of the DUT used by the hand-computed checks.
    int ready_cyc = 0, en_rise_cyc = 0, en_run = 0, en_len_last = 0;
    int busy_run = 0, busy_len_last = 0, n_r1 = 0, n_en_rise = 0;
    bit en_prev = 1'b0, busy_prev = 1'b0;
    int gq[$];
    int rq[$];

    initial begin
        forever begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                ready_cyc = cyc;
                gq.push_back(int'(grant));
                rq.push_back(cyc);
                if (req1_ready) n_r1++;
            end
            if (LCD_EN && !en_prev) begin
                en_rise_cyc = cyc;
                n_en_rise++;
                en_run = 0;
            end
            if (LCD_EN) en_run++;
            if (!LCD_EN && en_prev) en_len_last = en_run;
            if (busy && !busy_prev) busy_run = 0;
            if (busy) busy_run++;
            if (!busy && busy_prev) busy_len_last = busy_run;
            en_prev = LCD_EN;
            busy_prev = busy;
        end
    end

    task automatic set_req(input int w, input logic v, input logic rs, input logic [7:0] d);
        if (w == 0) begin
            req0_valid = v; req0_rs = rs; req0_data = d;
        end else begin
            req1_valid = v; req1_rs = rs; req1_data = d;
        end
    endtask

    // Presents a byte and holds it until the model says this writer was granted.
    task automatic send(input int w, input logic rs, input logic [7:0] d, input bit drop);
        int k;
        k = 0;
        set_req(w, 1'b1, rs, d);
        do begin
            @(negedge clk);
            k++;
        end while (!(m_active && m_t == 0 && m_grant == w[0]) && k < 2000);
        if (k >= 2000) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_bound: writer %0d not granted within %0d cycles", w, k);
        end
        if (drop) set_req(w, 1'b0, rs, d);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (m_active && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 5000) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_bound: bus still busy after %0d cycles", k);
        end
        @(negedge clk);
    endtask

    task automatic rand_writer(input int w);
        logic       rs;
        logic [7:0] d;
        for (int n = 0; n < 10; n++) begin
            repeat ($urandom_range(0, 30)) @(negedge clk);
            rs = 1'($urandom_range(0, 1));
            d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
            if ($urandom_range(0, 7) == 0 && m_active) begin
                set_req(w, 1'b1, rs, d);
                @(negedge clk);
                set_req(w, 1'b0, rs, d);
            end else begin
                send(w, rs, d, 1'b1);
            end
        end
    endtask

    int c0, r1_before, en_before;
`ifdef LCD_ARB_FIXED_PRIORITY_EN
    int exp_g[4] = '{0, 0, 1, 1};
`else
    int exp_g[4] = '{0, 1, 0, 1};
`endif

    initial begin
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (200) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_en_rises", n_en_rise, 0);

        // Single data write
        c0 = cyc;
        send(0, 1'b1, 8'h43, 1'b1);
        wait_idle();
        chk("ready_latency", ready_cyc - c0, 1);
        chk("en_rise_offset", en_rise_cyc - ready_cyc, 4);
        chk("en_high_len", en_len_last, 25);
        chk("busy_len_43", busy_len_last, 83);
        chk("data_43", {LCD_RS, LCD_DATA}, 9'h143);

        // Long command, then a normal command
        send(1, 1'b0, 8'h01, 1'b1);
        wait_idle();
        chk("busy_len_01", busy_len_last, 333);
        chk("model_len_01", txn_len(1'b0, 8'h01), 333);
        chk("model_len_data01", txn_len(1'b1, 8'h01), 83);
        send(1, 1'b0, 8'h80, 1'b1);
        wait_idle();
        chk("busy_len_80", busy_len_last, 83);

        // Contention: both writers keep a request pending for two transactions
        gq.delete();
        rq.delete();
        fork
            begin send(0, 1'b1, 8'h30, 1'b0); send(0, 1'b1, 8'h31, 1'b1); end
            begin send(1, 1'b1, 8'h40, 1'b0); send(1, 1'b1, 8'h41, 1'b1); end
        join
        wait_idle();
        chk("grant_count", gq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < gq.size()) chk("grant_seq", gq[i], exp_g[i]);
        end
        for (int i = 0; i + 1 < rq.size(); i++) chk("grant_spacing", rq[i+1] - rq[i], 84);

        // Reset in the middle of the EN pulse
        send(0, 1'b1, 8'h41, 1'b1);
        repeat (10) @(negedge clk);
        chk("pre_reset_en", LCD_EN, 1);
        #5 resetn = 1'b0;
        #1;
        chk("async_en_drop", LCD_EN, 0);
        chk("async_busy_drop", busy, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        send(0, 1'b1, 8'h45, 1'b1);
        wait_idle();
        chk("post_reset_len", busy_len_last, 83);
        chk("post_reset_data", {LCD_RS, LCD_DATA}, 9'h145);

        // Withdrawn request while busy
        r1_before = n_r1;
        en_before = n_en_rise;
        send(0, 1'b1, 8'h30, 1'b1);
        repeat (5) @(negedge clk);
        set_req(1, 1'b1, 1'b1, 8'h55);
        @(negedge clk);
        set_req(1, 1'b0, 1'b1, 8'h55);
        wait_idle();
        repeat (20) @(negedge clk);
        chk("withdraw_no_r1", n_r1 - r1_before, 0);
        chk("withdraw_one_en", n_en_rise - en_before, 1);

        // Randomized traffic from both writers
        fork
            rand_writer(0);
            rand_writer(1);
        join
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
